// File: rtl/login_authenticator_pkg.sv
// Shared definitions for the login authenticator: FSM states, display codes,
// password-region defaults and the ROM address helper. LOGIN_LOCKOUT_EN adds the LOCKED state.
package login_authenticator_pkg;

    localparam int unsigned PASS_LEN_DEF    = 32'd4;
    localparam int unsigned PASS_STRIDE_DEF = 32'd8;
    localparam int unsigned PASS_BASE       = 32'd0;

    typedef enum logic [2:0] {
        S_GET_ID   = 3'd0,
        S_GET_PASS = 3'd1,
        S_FETCH    = 3'd2,
        S_COMPARE  = 3'd3,
        S_DECIDE   = 3'd4,
        S_GRANTED  = 3'd5,
        S_DENIED   = 3'd6
`ifdef LOGIN_LOCKOUT_EN
        ,S_LOCKED  = 3'd7
`endif
    } state_e;

    typedef enum logic [3:0] {
        DISP_ID      = 4'd1,
        DISP_PASS    = 4'd2,
        DISP_CHECK   = 4'd3,
        DISP_GRANTED = 4'd4,
        DISP_DENIED  = 4'd5,
        DISP_LOCKED  = 4'd6
    } disp_e;

    function automatic logic [3:0] disp_code(input state_e s);
        disp_e d;
        case (s)
            S_GET_ID:   d = DISP_ID;
            S_GET_PASS: d = DISP_PASS;
            S_FETCH:    d = DISP_PASS;
            S_COMPARE:  d = DISP_PASS;
            S_DECIDE:   d = DISP_CHECK;
            S_GRANTED:  d = DISP_GRANTED;
            S_DENIED:   d = DISP_DENIED;
`ifdef LOGIN_LOCKOUT_EN
            S_LOCKED:   d = DISP_LOCKED;
`endif
            default:    d = DISP_ID;
        endcase
        return d;
    endfunction

    // ROM word holding digit idx of user uid's password; truncated to the 6-bit ROM space.
    function automatic logic [5:0] pass_addr(input logic [1:0] uid, input logic [2:0] idx,
                                             input int unsigned stride);
        int unsigned a;
        a = PASS_BASE + 32'(uid) * stride + 32'(idx);
        return a[5:0];
    endfunction

endpackage

// File: rtl/login_authenticator_if.sv
// Button/switch inputs, ROM port and status outputs of the login authenticator.
// The design side uses the slave modport; the driving environment uses master.
interface login_authenticator_if;
    logic       enterPulse;
    logic       clearPulse;
    logic [3:0] digitIn;
    logic       logOutSignal;
    logic [3:0] romData;
    logic [5:0] romAddress;
    logic       loggedIn;
    logic [5:0] passBeginAddress;
    logic [1:0] userId;
    logic [2:0] digitCount;
    logic [3:0] displayState;
    logic       deniedPulse;

    modport master (
        output enterPulse, clearPulse, digitIn, logOutSignal, romData,
        input  romAddress, loggedIn, passBeginAddress, userId, digitCount,
               displayState, deniedPulse
    );

    modport slave (
        input  enterPulse, clearPulse, digitIn, logOutSignal, romData,
        output romAddress, loggedIn, passBeginAddress, userId, digitCount,
               displayState, deniedPulse
    );
endinterface

// File: rtl/login_authenticator_lockout_timer.sv
// login_lockout_timer: counts LOCK_CYCLES clocks after start; done_o is high in the last one.
// Only present when LOGIN_LOCKOUT_EN is defined.
`ifdef LOGIN_LOCKOUT_EN
module login_lockout_timer #(
    parameter int unsigned LOCK_CYCLES = 32'd1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic done_o
);
    localparam int unsigned W = (LOCK_CYCLES > 32'd1) ? $clog2(LOCK_CYCLES) : 32'd1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         act_q, act_d;
    logic         done_q, done_d;

    // Next count: load on start, walk down to zero, then go idle.
    always_comb begin
        cnt_d = cnt_q;
        act_d = act_q;
        if (start_i) begin
            cnt_d = W'(LOCK_CYCLES - 32'd1);
            act_d = 1'b1;
        end else if (act_q && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else if (act_q) begin
            act_d = 1'b0;
        end else begin
            act_d = 1'b0;
        end
        done_d = act_d && (cnt_d == {W{1'b0}});
    end

    // Counter state and registered done flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= {W{1'b0}};
            act_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            act_q  <= act_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
endmodule
`endif

// File: rtl/login_authenticator.sv
// User-ID plus password login gate in front of the game controller.
// Define LOGIN_LOCKOUT_EN to lock the block for LOCK_CYCLES after MAX_ATTEMPTS failed logins.
module login_authenticator
    import login_authenticator_pkg::*;
#(
    parameter int unsigned NUM_USERS    = 32'd4,
    parameter int unsigned PASS_LEN     = PASS_LEN_DEF,
    parameter int unsigned PASS_STRIDE  = PASS_STRIDE_DEF
`ifdef LOGIN_LOCKOUT_EN
    ,parameter int unsigned MAX_ATTEMPTS = 32'd3
    ,parameter int unsigned LOCK_CYCLES  = 32'd1000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    login_authenticator_if.slave  bus
);
    if ((NUM_USERS < 32'd1) || (NUM_USERS > 32'd4) || (PASS_LEN < 32'd1) || (PASS_LEN > 32'd7) ||
        (PASS_BASE + (NUM_USERS - 32'd1) * PASS_STRIDE + PASS_LEN - 32'd1 > 32'd63)) begin : g_bad_cfg
        $error("login_authenticator: password region does not fit the 6-bit ROM address");
    end

    state_e     state_q, state_d;
    logic [1:0] user_q, user_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] digit_q, digit_d;
    logic       mism_q, mism_d;
    logic [5:0] addr_q, addr_d;
    logic       logged_q, logged_d;
    logic [5:0] pba_q, pba_d;
    logic       den_q, den_d;
    logic [3:0] disp_q, disp_d;
    logic       clear_ok_s;

`ifdef LOGIN_LOCKOUT_EN
    localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 32'd1);
    logic [AW-1:0] att_q, att_d;
    logic          lock_start_s, lock_done_s;

    assign clear_ok_s   = (state_q != S_GRANTED) && (state_q != S_LOCKED);
    assign lock_start_s = (state_q != S_LOCKED) && (state_d == S_LOCKED);

    login_lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_timer (
        .clk     (clk),
        .rst     (rst),
        .start_i (lock_start_s),
        .done_o  (lock_done_s)
    );
`else
    assign clear_ok_s = (state_q != S_GRANTED);
`endif

    // Next-state and next-output logic; clearPulse outranks every other event.
    always_comb begin
        state_d  = state_q;
        user_d   = user_q;
        cnt_d    = cnt_q;
        digit_d  = digit_q;
        mism_d   = mism_q;
        addr_d   = addr_q;
        logged_d = logged_q;
        pba_d    = pba_q;
        den_d    = 1'b0;
`ifdef LOGIN_LOCKOUT_EN
        att_d    = att_q;
`endif
        if (bus.clearPulse && clear_ok_s) begin
            state_d = S_GET_ID;
            cnt_d   = 3'd0;
            mism_d  = 1'b0;
        end else begin
            case (state_q)
                S_GET_ID: begin
                    if (bus.enterPulse && ({28'd0, bus.digitIn} < NUM_USERS)) begin
                        user_d  = bus.digitIn[1:0];
                        cnt_d   = 3'd0;
                        mism_d  = 1'b0;
                        state_d = S_GET_PASS;
                    end else begin
                        state_d = S_GET_ID;
                    end
                end
                S_GET_PASS: begin
                    if (bus.enterPulse) begin
                        digit_d = bus.digitIn;
                        addr_d  = pass_addr(user_q, cnt_q, PASS_STRIDE);
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_GET_PASS;
                    end
                end
                S_FETCH: state_d = S_COMPARE;
                S_COMPARE: begin
                    // Non-decimal digits can never be valid, whatever the ROM holds.
                    mism_d = mism_q | (digit_q != bus.romData) | (digit_q > 4'd9);
                    cnt_d  = cnt_q + 3'd1;
                    if ((32'(cnt_q) + 32'd1) == PASS_LEN) begin
                        state_d = S_DECIDE;
                    end else begin
                        state_d = S_GET_PASS;
                    end
                end
                S_DECIDE: begin
                    if (!mism_q) begin
                        state_d  = S_GRANTED;
                        logged_d = 1'b1;
                        pba_d    = pass_addr(user_q, 3'd0, PASS_STRIDE);
`ifdef LOGIN_LOCKOUT_EN
                        att_d    = {AW{1'b0}};
`endif
                    end else begin
                        state_d = S_DENIED;
                        den_d   = 1'b1;
`ifdef LOGIN_LOCKOUT_EN
                        att_d   = att_q + AW'(1);
`endif
                    end
                end
                S_DENIED: begin
                    cnt_d  = 3'd0;
                    mism_d = 1'b0;
`ifdef LOGIN_LOCKOUT_EN
                    if (32'(att_q) >= MAX_ATTEMPTS) begin
                        state_d = S_LOCKED;
                    end else begin
                        state_d = S_GET_PASS;
                    end
`else
                    state_d = S_GET_PASS;
`endif
                end
                S_GRANTED: begin
                    if (bus.logOutSignal) begin
                        state_d  = S_GET_ID;
                        logged_d = 1'b0;
                        pba_d    = 6'd0;
                        cnt_d    = 3'd0;
                        mism_d   = 1'b0;
                    end else begin
                        state_d = S_GRANTED;
                    end
                end
`ifdef LOGIN_LOCKOUT_EN
                S_LOCKED: begin
                    if (lock_done_s) begin
                        state_d = S_GET_ID;
                        att_d   = {AW{1'b0}};
                    end else begin
                        state_d = S_LOCKED;
                    end
                end
`endif
                default: begin
                    state_d = S_GET_ID;
                    cnt_d   = 3'd0;
                    mism_d  = 1'b0;
                end
            endcase
        end
        disp_d = disp_code(state_d);
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_GET_ID;
            user_q   <= 2'd0;
            cnt_q    <= 3'd0;
            digit_q  <= 4'd0;
            mism_q   <= 1'b0;
            addr_q   <= 6'd0;
            logged_q <= 1'b0;
            pba_q    <= 6'd0;
            den_q    <= 1'b0;
            disp_q   <= 4'd1;
`ifdef LOGIN_LOCKOUT_EN
            att_q    <= {AW{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            user_q   <= user_d;
            cnt_q    <= cnt_d;
            digit_q  <= digit_d;
            mism_q   <= mism_d;
            addr_q   <= addr_d;
            logged_q <= logged_d;
            pba_q    <= pba_d;
            den_q    <= den_d;
            disp_q   <= disp_d;
`ifdef LOGIN_LOCKOUT_EN
            att_q    <= att_d;
`endif
        end
    end

    assign bus.romAddress       = addr_q;
    assign bus.loggedIn         = logged_q;
    assign bus.passBeginAddress = pba_q;
    assign bus.userId           = user_q;
    assign bus.digitCount       = cnt_q;
    assign bus.displayState     = disp_q;
    assign bus.deniedPulse      = den_q;
endmodule

// File: tb/tb_login_authenticator.sv
// Directed bench for login_authenticator: ROM model with user 1 = 3,7,1,9 at words 8..11.
// The lockout steps run only when LOGIN_LOCKOUT_EN is defined.
module tb_login_authenticator;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [3:0] rom [64];

    login_authenticator_if bus ();

`ifdef LOGIN_LOCKOUT_EN
    login_authenticator #(.LOCK_CYCLES(32'd20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`else
    login_authenticator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency ROM.
    always @(posedge clk) bus.romData <= rom[bus.romAddress];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] d);
        bus.digitIn    = d;
        bus.enterPulse = 1'b1;
        @(negedge clk);
        bus.enterPulse = 1'b0;
    endtask

    // Leaves the FSM in DECIDE after the last digit.
    task automatic enter_digits(input logic [15:0] ds);
        for (int i = 0; i < 4; i++) begin
            press(ds[15-4*i -: 4]);
            step();
            step();
        end
    endtask

    initial begin
        logic [11:0] rest;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < 64; i++) rom[i] = 4'd0;
        rom[0] = 4'd1; rom[1] = 4'd2; rom[2]  = 4'd3; rom[3]  = 4'd4;
        rom[8] = 4'd3; rom[9] = 4'd7; rom[10] = 4'd1; rom[11] = 4'd9;
        rst = 1'b0;
        bus.enterPulse   = 1'b0;
        bus.clearPulse   = 1'b0;
        bus.logOutSignal = 1'b0;
        bus.digitIn      = 4'd0;
        step();
        step();
        check("rst_loggedIn", bus.loggedIn, 32'd0);
        check("rst_pba", bus.passBeginAddress, 32'd0);
        check("rst_userId", bus.userId, 32'd0);
        check("rst_digitCount", bus.digitCount, 32'd0);
        check("rst_romAddress", bus.romAddress, 32'd0);
        check("rst_denied", bus.deniedPulse, 32'd0);
        check("rst_display", bus.displayState, 32'd1);
        rst = 1'b1;
        step();

        press(4'd5);
        check("bad_id_display", bus.displayState, 32'd1);
        check("bad_id_userId", bus.userId, 32'd0);
        press(4'd1);
        check("id_display", bus.displayState, 32'd2);
        check("id_userId", bus.userId, 32'd1);

        bus.clearPulse = 1'b1;
        press(4'd3);
        bus.clearPulse = 1'b0;
        check("clr_enter_display", bus.displayState, 32'd1);
        check("clr_enter_count", bus.digitCount, 32'd0);

        press(4'd1);
        press(4'd3);
        check("addr_d0", bus.romAddress, 32'd8);
        check("fetch_display", bus.displayState, 32'd2);
        press(4'd5);
        step();
        check("drop_count", bus.digitCount, 32'd1);
        rest = 12'h719;
        for (int i = 0; i < 3; i++) begin
            press(rest[11-4*i -: 4]);
            check("addr_dn", bus.romAddress, 32'd9 + 32'(i));
            step();
            step();
        end
        check("decide_display", bus.displayState, 32'd3);
        check("decide_loggedIn", bus.loggedIn, 32'd0);
        step();
        check("grant_loggedIn", bus.loggedIn, 32'd1);
        check("grant_pba", bus.passBeginAddress, 32'd8);
        check("grant_display", bus.displayState, 32'd4);

        bus.logOutSignal = 1'b1;
        step();
        bus.logOutSignal = 1'b0;
        check("logout_loggedIn", bus.loggedIn, 32'd0);
        check("logout_pba", bus.passBeginAddress, 32'd0);
        check("logout_display", bus.displayState, 32'd1);

        press(4'd1);
        enter_digits(16'h3729);
        step();
        check("deny_pulse", bus.deniedPulse, 32'd1);
        check("deny_display", bus.displayState, 32'd5);
        check("deny_loggedIn", bus.loggedIn, 32'd0);
        step();
        check("deny_pulse_end", bus.deniedPulse, 32'd0);
        check("deny_count", bus.digitCount, 32'd0);
        check("deny_userId", bus.userId, 32'd1);
        check("deny_retry_display", bus.displayState, 32'd2);

        press(4'd3);
        step();
        #2 rst = 1'b0;
        #1;
        check("midrst_display", bus.displayState, 32'd1);
        check("midrst_userId", bus.userId, 32'd0);
        check("midrst_romAddress", bus.romAddress, 32'd0);
        check("midrst_count", bus.digitCount, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step();

`ifdef LOGIN_LOCKOUT_EN
        press(4'd1);
        for (int k = 0; k < 3; k++) begin
            enter_digits(16'h3729);
            step();
            step();
        end
        check("lock_display", bus.displayState, 32'd6);
        for (int k = 0; k < 19; k++) begin
            bus.clearPulse = 1'b1;
            press(4'd1);
            bus.clearPulse = 1'b0;
        end
        check("lock_last_display", bus.displayState, 32'd6);
        step();
        check("unlock_display", bus.displayState, 32'd1);
        press(4'd1);
        enter_digits(16'h3719);
        step();
        check("unlock_login", bus.loggedIn, 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/login_authenticator.md
Name: login_authenticator

Overview:
- Upstream stage of the top-level game controller: gates play behind a user-ID plus 4-digit password login.
- Password digits come from the shared sequence/password ROM, one digit per address, 1-cycle read latency.
- Drives loggedIn and passBeginAddress to the game controller; the controller's logOut request returns the block to ID entry.

Parameters:
- NUM_USERS, 4, number of valid user IDs (0..NUM_USERS-1)
- PASS_LEN, 4, password digits per user
- PASS_STRIDE, 8, ROM words reserved per user; passBeginAddress = userId*PASS_STRIDE
- MAX_ATTEMPTS, 3, consecutive failed logins before lockout (LOCKOUT_EN only)
- LOCK_CYCLES, 1000, lockout duration in clk cycles (LOCKOUT_EN only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-low reset
- enterPulse  in  1  one-cycle pulse from debounced Button1: accept digitIn
- clearPulse  in  1  one-cycle pulse from debounced Button2: abort, back to ID entry
- digitIn  in  4  switch digit 0-9
- logOutSignal  in  1  level/pulse from game controller requesting logout
- romData  in  4  ROM read data, valid 1 cycle after romAddress
- romAddress  out  6  ROM read address
- loggedIn  out  1  high while authenticated
- passBeginAddress  out  6  userId*PASS_STRIDE, held while loggedIn
- userId  out  2  latched user ID
- digitCount  out  3  password digits accepted so far (0..PASS_LEN)
- displayState  out  4  1=ID, 2=PASS, 3=CHECK, 4=GRANTED, 5=DENIED, 6=LOCKED
- deniedPulse  out  1  one-cycle pulse on failed login

Behaviour:
- Async reset (rst=0): state GET_ID; loggedIn=0, passBeginAddress=0, userId=0, digitCount=0, romAddress=0, deniedPulse=0, displayState=1, mismatch flag=0, attempt counter=0.
- GET_ID: on enterPulse with digitIn<NUM_USERS, latch userId and go to GET_PASS with digitCount=0 and mismatch=0. Invalid ID (>=NUM_USERS) is ignored; state is held.
- GET_PASS: on enterPulse, latch digitIn, drive romAddress=userId*PASS_STRIDE+digitCount, go to FETCH.
- FETCH (1 cycle): go to COMPARE; romData is valid in COMPARE.
- COMPARE (1 cycle): mismatch |= (latched digit != romData); digitCount++.
  - If digitCount reaches PASS_LEN, go to DECIDE; otherwise return to GET_PASS.
- Digits >9 are accepted and always mismatch.
- Entry latency: 2 cycles from enterPulse to the next digit being accepted. enterPulse in FETCH or COMPARE is dropped.
- DECIDE (1 cycle):
  - mismatch=0: go to GRANTED; loggedIn=1 from the next cycle; passBeginAddress=userId*PASS_STRIDE; attempt counter cleared.
  - mismatch=1: go to DENIED; deniedPulse=1 for exactly 1 cycle; attempt counter++.
- Early rejection: a wrong digit does not end entry; the user always enters all PASS_LEN digits, so a wrong digit is not revealed early.
- DENIED: return to GET_PASS with the same userId, digitCount=0, mismatch=0. Holds 1 cycle.
- GRANTED: loggedIn held until logOutSignal=1; then go to GET_ID with loggedIn=0 and passBeginAddress=0 on the next cycle.
- clearPulse in any state except GRANTED and LOCKED: go to GET_ID; digitCount and mismatch cleared. clearPulse does not change the attempt count.
- Simultaneous events:
  - clearPulse beats enterPulse.
  - logOutSignal is ignored outside GRANTED.
- Width: userId*PASS_STRIDE+digitCount is computed in 6 bits. The parameters must keep it <64; this is a compile-time check.

Optional Feature:
- Macro: LOGIN_LOCKOUT_EN.
- With the macro defined:
  - When the attempt counter reaches MAX_ATTEMPTS, DENIED goes to LOCKED instead of GET_PASS.
  - LOCKED ignores all inputs, including clearPulse, and counts LOCK_CYCLES.
  - It then goes to GET_ID and clears the attempt counter.
  - displayState=6 in LOCKED.
- Without the macro: no lockout counter or LOCKED state exists; retries are unlimited and displayState=6 is never produced.

Decomposition:
- Shared package holds:
  - State encoding / displayState codes.
  - PASS_STRIDE and PASS_LEN defaults.
  - ROM map constant for the password region base.
- One natural sub-module: login_lockout_timer, the LOCK_CYCLES down-counter with start/done. It is instantiated only under LOGIN_LOCKOUT_EN.

Test Plan:
- Reset mid-COMPARE (rst low 1 cycle) -> all outputs return to reset values immediately; displayState=1.
- ROM user1 holds 3,7,1,9: enter ID 1, then 3,7,1,9 -> romAddress 8,9,10,11 in turn; loggedIn=1 3 cycles after the last enterPulse; passBeginAddress=8.
- Same user enters 3,7,2,9 -> deniedPulse once, loggedIn stays 0, digitCount returns to 0, userId stays 1.
- Enter ID 5 with NUM_USERS=4 -> no state change; then clearPulse and enterPulse in the same cycle during GET_PASS -> GET_ID wins.
- Logged in, assert logOutSignal -> loggedIn=0 and passBeginAddress=0 next cycle; displayState=1.
- LOGIN_LOCKOUT_EN with LOCK_CYCLES=20: 3 wrong logins -> displayState=6; enterPulse is ignored for 20 cycles, then the block goes to GET_ID and a correct login succeeds.
